// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - stimulus/response checker for 2-input combinational gates
//
// Sweeps {a_out,b_out} through 00,01,10,11, holding each vector HOLD_CYCLES clocks,
// samples y_in on the last clock of each hold and compares it with TRUTH_TABLE[{a,b}].
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      sweep request, honoured only when not busy
//   y_in       output of the gate under test
//   a_out      gate input a
//   b_out      gate input b
//   busy       sweep in progress
//   done       sweep finished; held until the next start
//   pass       done with no mismatching vector
//   err_count  mismatching vectors in the last sweep (saturating)
//   fail_vec   bit k set when vector k={a,b} mismatched
module gate_truth_checker #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] TRUTH_TABLE = 4'b0111,
    parameter int         ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int                 CNT_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_idx, w_idx_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_a, w_a_nx;
    logic             r_b, w_b_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             r_pass, w_pass_nx;
    logic [ERR_W-1:0] r_err, w_err_nx;
    logic [3:0]       r_fail, w_fail_nx;
    logic             w_mismatch;

    assign w_mismatch = (y_in != TRUTH_TABLE[r_idx]);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        w_pass_nx  = r_pass;
        w_err_nx   = r_err;
        w_fail_nx  = r_fail;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Results of the previous sweep are discarded at the launch edge.
                    w_state_nx = S_DRIVE;
                    w_idx_nx   = 2'd0;
                    w_cnt_nx   = '0;
                    w_a_nx     = 1'b0;
                    w_b_nx     = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_done_nx  = 1'b0;
                    w_pass_nx  = 1'b0;
                    w_err_nx   = '0;
                    w_fail_nx  = 4'b0000;
                end
            end
            S_DRIVE: begin
                if (r_cnt == CNT_LAST) begin
                    // Last clock of the hold: y_in has settled, judge this vector.
                    if (w_mismatch) begin
                        if (r_err != ERR_MAX) begin
                            w_err_nx = r_err + ERR_W'(1);
                        end
                        w_fail_nx[r_idx] = 1'b1;
                    end
                    w_cnt_nx = '0;
                    if (r_idx == 2'd3) begin
                        // a/b stay at 11 while the result is presented.
                        w_state_nx = S_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_pass_nx  = (w_err_nx == '0);
                    end else begin
                        w_idx_nx       = r_idx + 2'd1;
                        {w_a_nx, w_b_nx} = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= 4'b0000;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_pass  <= w_pass_nx;
            r_err   <= w_err_nx;
            r_fail  <= w_fail_nx;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench for gate_truth_checker
module tb_gate_truth_checker;

    localparam int         H0  = 10;
    localparam int         H1  = 2;
    localparam logic [3:0] TT0 = 4'b0111;
    localparam logic [3:0] TT1 = 4'b0110;

    typedef struct {
        int inst;
        int cyc;
        int ab;
        bit busy;
        bit done;
        bit zero_res;
    } ab_e;

    typedef struct {
        int       inst;
        int       cyc;
        int       err;
        logic [3:0] fail;
    } res_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic       y_s     [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [2:0] err_s   [2];
    logic [3:0] fail_s  [2];

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ab_e  ab_q[$];
    res_e res_q[$];
    bit   done_prev [2];
    ab_e  m_e;
    res_e m_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_truth_checker #(.HOLD_CYCLES(H0), .TRUTH_TABLE(TT0), .ERR_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .y_in(y_s[0]),
        .a_out(a_s[0]), .b_out(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fail_s[0])
    );

    gate_truth_checker #(.HOLD_CYCLES(H1), .TRUTH_TABLE(TT1), .ERR_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .y_in(y_s[1]),
        .a_out(a_s[1]), .b_out(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fail_s[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_a"},    a_s[i],    0);
        chk({tag, "_b"},    b_s[i],    0);
        chk({tag, "_busy"}, busy_s[i], 0);
        chk({tag, "_done"}, done_s[i], 0);
        chk({tag, "_pass"}, pass_s[i], 0);
        chk({tag, "_err"},  err_s[i],  0);
        chk({tag, "_fail"}, fail_s[i], 0);
    endtask

    // One sweep on instance i against a gate whose truth table is gtt.
    // Called and returning at a falling edge; abort_j >= 0 applies reset
    // during cycle abort_j of the sweep.
    task automatic sweep(input int i, input logic [3:0] gtt, input bit noise,
                         input bit hold_after, input int abort_j);
        int         h;
        int         c0;
        int         ne;
        logic [3:0] tt;
        logic [3:0] fv;
        logic       bad;
        h  = (i == 0) ? H0 : H1;
        tt = (i == 0) ? TT0 : TT1;
        start_s[i] = 1'b1;
        c0 = cyc + 1;
        for (int j = 0; j <= 4 * h; j++) begin
            ab_q.push_back('{i, c0 + j, (j < 4 * h) ? j / h : 3, j < 4 * h, j == 4 * h, j < h});
        end
        fv = gtt ^ tt;
        ne = 0;
        for (int k = 0; k < 4; k++) ne += int'(fv[k]);
        res_q.push_back('{i, c0 + 4 * h, ne, fv});
        y_s[i] = gtt[{a_s[i], b_s[i]}];
        for (int j = 0; j < 4 * h; j++) begin
            @(negedge clk);
            if (j == abort_j) begin
                #2;
                rst = 1'b1;
                start_s[i] = 1'b0;
                #1;
                chk_zero("abort", i);
                ab_q.delete();
                res_q.delete();
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            start_s[i] = (noise && j <= 4 * h - 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
            bad = noise && ((j + 1) % h != 0) && ($urandom_range(0, 1) == 1);
            y_s[i] = gtt[{a_s[i], b_s[i]}] ^ bad;
        end
        @(negedge clk);
        start_s[i] = hold_after;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_prev[0] = 1'b0;
            done_prev[1] = 1'b0;
        end else begin
            while (ab_q.size() > 0 && ab_q[0].cyc <= cyc) begin
                m_e = ab_q.pop_front();
                chk("ab_cycle", m_e.cyc, cyc);
                chk("ab_vec",   {a_s[m_e.inst], b_s[m_e.inst]}, m_e.ab);
                chk("busy",     busy_s[m_e.inst], m_e.busy);
                chk("done",     done_s[m_e.inst], m_e.done);
                if (m_e.zero_res) begin
                    chk("err_cleared",  err_s[m_e.inst],  0);
                    chk("fail_cleared", fail_s[m_e.inst], 0);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (done_s[i] && !done_prev[i]) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        m_r = res_q.pop_front();
                        chk("res_inst",  i, m_r.inst);
                        chk("done_cyc",  cyc, m_r.cyc);
                        chk("err_count", err_s[i], m_r.err);
                        chk("fail_vec",  fail_s[i], m_r.fail);
                        chk("pass",      pass_s[i], m_r.err == 0);
                    end
                end
                done_prev[i] = done_s[i];
            end
        end
    end

    initial begin
        rst = 1'b1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        y_s[0] = 1'b0;
        y_s[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset0", 0);
        chk_zero("reset1", 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sweep(0, 4'b0111, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        sweep(0, 4'b1000, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        sweep(0, 4'b0011, 1'b1, 1'b1, -1);
        sweep(0, 4'($urandom_range(0, 15)), 1'b1, 1'b1, -1);
        sweep(0, 4'b0111, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        sweep(0, 4'b0000, 1'b1, 1'b0, 2 * H0 + 3);
        chk_zero("post_abort1", 1);
        sweep(0, 4'b0111, 1'b0, 1'b0, -1);
        repeat (2) @(negedge clk);

        sweep(1, 4'b0110, 1'b0, 1'b0, -1);
        repeat (2) @(negedge clk);
        sweep(1, 4'b1001, 1'b1, 1'b1, -1);
        sweep(1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            sweep(n % 2, 4'($urandom_range(0, 15)), 1'b1, 1'b0, -1);
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("pending_ab",  ab_q.size(),  0);
        chk("pending_res", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
